// File: rtl/or1k_wb_mem_responder.sv
//------------------------------------------------------------------------------
// or1k_wb_mem_responder
//
// Wishbone B3 slave memory for the OR1K instruction or data master port (one
// instance per bus). Word-organised SRAM with byte enables, classic cycles and
// incrementing bursts (linear, wrap4, wrap8, wrap16). A programmable number of
// wait states is inserted before the first acknowledge of each access/burst.
//
// Build option:
//   OR1K_WB_MEM_RESPONDER_ERR_EN  defined   -> addresses outside the window
//                                              [BASE_ADDR, BASE_ADDR+capacity)
//                                              are terminated with err_o.
//                                 undefined -> no window check; the word index
//                                              is wb_adr_i[MEM_ADDR_WIDTH+1:2]
//                                              (aliases modulo capacity) and
//                                              err_o is never asserted.
//
// Parameters:
//   MEM_ADDR_WIDTH  word-index bits, capacity = 4*2**MEM_ADDR_WIDTH bytes
//   BASE_ADDR       byte base of the window, aligned to the capacity
//   WAIT_STATES     idle cycles before the first ack of each access/burst
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   wb_adr_i        byte address, bits [1:0] ignored
//   wb_dat_i        write data
//   wb_sel_i        byte enables, sel[3] covers bits 31:24
//   wb_we_i         1 = write
//   wb_cyc_i        bus cycle
//   wb_stb_i        strobe
//   wb_cti_i        000 classic, 010 incrementing burst, 111 end of burst
//   wb_bte_i        00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   wb_dat_o        read data, valid while wb_ack_o = 1
//   wb_ack_o        normal termination
//   wb_err_o        error termination
//   wb_rty_o        retry, always 0
//------------------------------------------------------------------------------
module or1k_wb_mem_responder #(
   parameter int unsigned MEM_ADDR_WIDTH = 14,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned WAIT_STATES    = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o
);

   localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;
   localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

   localparam logic [2:0] CTI_INCR = 3'b010;
   localparam logic [2:0] CTI_EOB  = 3'b111;

   localparam logic [1:0] BTE_WRAP4  = 2'b01;
   localparam logic [1:0] BTE_WRAP8  = 2'b10;
   localparam logic [1:0] BTE_WRAP16 = 2'b11;

   // IDLE  : waiting for a request
   // WAIT  : counting wait states before the first response
   // RESP  : first response (ack or err) is on the bus
   // BURST : subsequent burst beats, one per cycle
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_BURST
   } state_t;

   //---------------------------------------------------------------------------
   // Storage
   //---------------------------------------------------------------------------
   logic [31:0] mem [DEPTH];

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [29:0]      ptr_q;     // word address of the beat currently on the bus
   logic             burst_q;   // access was accepted as an incrementing burst
   logic [1:0]       bte_q;     // burst type latched at accept
   logic             ack_q;
   logic             err_q;
   logic [31:0]      dat_q;

   //---------------------------------------------------------------------------
   // Combinational helpers
   //---------------------------------------------------------------------------
   logic        req;
   logic [29:0] adr_word;
   logic [29:0] ptr_d;       // word address of the next burst beat
   logic [29:0] rd_word;     // word whose response is loaded at this edge
   logic [31:0] rd_data;
   logic        rd_ok;
   logic        wr_ok;
   logic        wr_en;

   assign req      = wb_cyc_i & wb_stb_i;
   assign adr_word = wb_adr_i[31:2];

   // Next burst address: linear bursts carry into the whole word address,
   // wrapping bursts only move inside their aligned 4/8/16-word block.
   // NOTE: every signal driven from always_comb gets a value on every path
   // (here a default first), otherwise a latch is inferred.
   always_comb begin
      ptr_d = ptr_q + 30'd1;
      case (bte_q)
         BTE_WRAP4:  ptr_d = {ptr_q[29:2], ptr_q[1:0] + 2'd1};
         BTE_WRAP8:  ptr_d = {ptr_q[29:3], ptr_q[2:0] + 3'd1};
         BTE_WRAP16: ptr_d = {ptr_q[29:4], ptr_q[3:0] + 4'd1};
         default:    ;
      endcase
   end

   // The response loaded at this edge belongs to: the incoming address when
   // answering straight from IDLE, the latched address at the end of the wait
   // period, or the next beat (prefetch) while a burst is running.
   always_comb begin
      case (state_q)
         ST_IDLE: rd_word = adr_word;
         ST_WAIT: rd_word = ptr_q;
         default: rd_word = ptr_d;
      endcase
   end

   assign rd_data = mem[rd_word[MEM_ADDR_WIDTH-1:0]];

`ifdef OR1K_WB_MEM_RESPONDER_ERR_EN
   // BASE_ADDR is aligned to the capacity, so a word is inside the window
   // exactly when its bits above the index match the base.
   localparam int unsigned TAG_W = 30 - MEM_ADDR_WIDTH;
   localparam logic [TAG_W-1:0] BASE_TAG = BASE_ADDR[31:MEM_ADDR_WIDTH+2];

   assign rd_ok = (rd_word[29:MEM_ADDR_WIDTH] == BASE_TAG);
   assign wr_ok = (adr_word[29:MEM_ADDR_WIDTH] == BASE_TAG);

   logic unused_bits;
   assign unused_bits = ^wb_adr_i[1:0];
`else
   assign rd_ok = 1'b1;
   assign wr_ok = 1'b1;

   logic unused_bits;
   assign unused_bits = ^{wb_adr_i[1:0], rd_word[29:MEM_ADDR_WIDTH]};
`endif

   // A write lands on the edge that completes the acknowledged beat. The
   // reset term drops a beat whose completing edge coincides with reset.
   assign wr_en = !rst && wb_stb_i && wb_we_i && ack_q && wr_ok;

   // NOTE: the memory array is deliberately left out of reset: contents must
   // survive a reset, and a resettable array cannot map onto SRAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) begin
               mem[adr_word[MEM_ADDR_WIDTH-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Control FSM with registered bus outputs
   //---------------------------------------------------------------------------
   // NOTE: state registers are assigned with non-blocking (<=) only, so every
   // register samples the values from before the edge regardless of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         burst_q <= 1'b0;
         bte_q   <= 2'b00;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // ack_q/err_q are low here; a request arriving right after a
               // response is only accepted one cycle later.
               if (req && !ack_q && !err_q) begin
                  ptr_q   <= adr_word;
                  burst_q <= (wb_cti_i == CTI_INCR);
                  bte_q   <= wb_bte_i;
                  cnt_q   <= '0;
                  if (WAIT_STATES == 0) begin
                     state_q <= ST_RESP;
                     ack_q   <= rd_ok;
                     err_q   <= !rd_ok;
                     dat_q   <= rd_ok ? rd_data : '0;
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= ST_RESP;
                  ack_q   <= rd_ok;
                  err_q   <= !rd_ok;
                  dat_q   <= rd_ok ? rd_data : '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ST_RESP, ST_BURST: begin
               // Stop after an error, after a classic response, when the
               // master withdraws (beat not consumed) or on end-of-burst.
               if (err_q || !burst_q || !req || (wb_cti_i == CTI_EOB)) begin
                  state_q <= ST_IDLE;
                  ack_q   <= 1'b0;
                  err_q   <= 1'b0;
               end else begin
                  state_q <= ST_BURST;
                  ptr_q   <= ptr_d;
                  ack_q   <= rd_ok;
                  err_q   <= !rd_ok;
                  dat_q   <= rd_ok ? rd_data : '0;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_or1k_wb_mem_responder.sv
//------------------------------------------------------------------------------
// tb_or1k_wb_mem_responder
//
// Two responders side by side: dut 0 (base 0x0000, no wait states) and
// dut 1 (base 0x1000, two wait states), each with 64 words. A word-array
// reference model per instance tracks memory contents; burst beat addresses
// and the window rule are computed arithmetically from the bus rules.
//------------------------------------------------------------------------------
module tb_or1k_wb_mem_responder;

   localparam int          AW    = 6;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] CAP   = 32'(DEPTH * 4);

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [31:0] adr   [2];
   logic [31:0] dat_w [2];
   logic [3:0]  sel   [2];
   logic        we    [2];
   logic        cyc   [2];
   logic        stb   [2];
   logic [2:0]  cti   [2];
   logic [1:0]  bte   [2];
   logic [31:0] dat_r [2];
   logic        ack   [2];
   logic        err   [2];
   logic        rty   [2];

   logic [31:0] mem_m [2][DEPTH];

   int total = 0;
   int bad   = 0;
   int cur   = 0;

   always #5 clk = ~clk;

   or1k_wb_mem_responder #(
      .MEM_ADDR_WIDTH (AW),
      .BASE_ADDR      (32'h0000_0000),
      .WAIT_STATES    (0)
   ) u_dut0 (
      .clk      (clk),
      .rst      (rst),
      .wb_adr_i (adr[0]),
      .wb_dat_i (dat_w[0]),
      .wb_sel_i (sel[0]),
      .wb_we_i  (we[0]),
      .wb_cyc_i (cyc[0]),
      .wb_stb_i (stb[0]),
      .wb_cti_i (cti[0]),
      .wb_bte_i (bte[0]),
      .wb_dat_o (dat_r[0]),
      .wb_ack_o (ack[0]),
      .wb_err_o (err[0]),
      .wb_rty_o (rty[0])
   );

   or1k_wb_mem_responder #(
      .MEM_ADDR_WIDTH (AW),
      .BASE_ADDR      (32'h0000_1000),
      .WAIT_STATES    (2)
   ) u_dut1 (
      .clk      (clk),
      .rst      (rst),
      .wb_adr_i (adr[1]),
      .wb_dat_i (dat_w[1]),
      .wb_sel_i (sel[1]),
      .wb_we_i  (we[1]),
      .wb_cyc_i (cyc[1]),
      .wb_stb_i (stb[1]),
      .wb_cti_i (cti[1]),
      .wb_bte_i (bte[1]),
      .wb_dat_o (dat_r[1]),
      .wb_ack_o (ack[1]),
      .wb_err_o (err[1]),
      .wb_rty_o (rty[1])
   );

   //---------------------------------------------------------------------------
   // Reference rules
   //---------------------------------------------------------------------------
   function automatic logic [31:0] base_of(input int d);
      return (d == 0) ? 32'h0000_0000 : 32'h0000_1000;
   endfunction

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'(a[31:2]) % DEPTH;
   endfunction

   function automatic bit err_exp(input int d, input logic [31:0] a);
`ifdef OR1K_WB_MEM_RESPONDER_ERR_EN
      return (a - base_of(d)) >= CAP;
`else
      return (d < 0) && (a == 32'h0);
`endif
   endfunction

   // Byte address of beat i of a burst starting at a0 with burst type b.
   function automatic logic [31:0] beat_addr(input logic [31:0] a0, input logic [1:0] b,
                                             input int i);
      int unsigned w0, n, blk;
      w0 = {2'b00, a0[31:2]};
      if (b == 2'b00) return (w0 + int'(i)) << 2;
      n   = 32'd2 << b;
      blk = w0 - (w0 % n);
      return (blk + ((w0 + int'(i)) % n)) << 2;
   endfunction

   function automatic logic [31:0] rand_addr(input int d);
      if ($urandom_range(7) == 0)
         return base_of(d) + CAP + (32'($urandom_range(DEPTH - 1)) << 2);
      return base_of(d) + (32'($urandom_range(DEPTH - 1)) << 2);
   endfunction

   task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] v,
                              input logic [3:0] s);
      for (int k = 0; k < 4; k++) begin
         if (s[k]) mem_m[d][idx_of(a)][8*k +: 8] = v[8*k +: 8];
      end
   endtask

   //---------------------------------------------------------------------------
   // Checking
   //---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s (dut %0d): got=%h expected=%h", tag, cur, got, exp);
      end
   endtask

   task automatic bus_idle(input int d);
      adr[d]   = '0;
      dat_w[d] = '0;
      sel[d]   = '0;
      we[d]    = 1'b0;
      cyc[d]   = 1'b0;
      stb[d]   = 1'b0;
      cti[d]   = CTI_CLASSIC;
      bte[d]   = 2'b00;
   endtask

   //---------------------------------------------------------------------------
   // Classic access on dut 'cur'; returns the data seen with the termination.
   //---------------------------------------------------------------------------
   task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
      int          n;
      bit          e;
      logic [31:0] expd;
      e    = err_exp(cur, a);
      expd = mem_m[cur][idx_of(a)];
      @(negedge clk);
      adr[cur]   = a;
      dat_w[cur] = d;
      sel[cur]   = s;
      we[cur]    = w;
      cti[cur]   = CTI_CLASSIC;
      bte[cur]   = 2'b00;
      cyc[cur]   = 1'b1;
      stb[cur]   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack[cur] && !err[cur] && n < 20);
      rd = dat_r[cur];
      check("classic_latency", 32'(n), 32'(ws_of(cur) + 1));
      check("classic_ack", 32'(ack[cur]), 32'(!e));
      check("classic_err", 32'(err[cur]), 32'(e));
      if (e) check("classic_err_dat", dat_r[cur], 32'h0);
      else if (!w) check("classic_rdata", dat_r[cur], expd);
      // Strobe still held here: the cycle after the response must stay quiet.
      @(negedge clk);
      check("classic_one_cycle", {30'b0, ack[cur], err[cur]}, 32'h0);
      bus_idle(cur);
      if (w && !e) model_write(cur, a, d, s);
   endtask

   //---------------------------------------------------------------------------
   // Burst on dut 'cur': nb beats consumed; ends with cti=111 on the last beat
   // (cti_end) or by withdrawing the strobe while the next beat is offered.
   //---------------------------------------------------------------------------
   task automatic burst(input logic w, input logic [31:0] a0, input logic [1:0] b,
                        input int nb, input bit cti_end);
      int          n;
      bit          e;
      bit          ended;
      logic [31:0] a;
      @(negedge clk);
      adr[cur]   = a0;
      dat_w[cur] = $urandom;
      sel[cur]   = 4'hF;
      we[cur]    = w;
      cti[cur]   = CTI_INCR;
      bte[cur]   = b;
      cyc[cur]   = 1'b1;
      stb[cur]   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack[cur] && !err[cur] && n < 20);
      check("burst_latency", 32'(n), 32'(ws_of(cur) + 1));
      ended = 1'b0;
      for (int i = 0; i < nb; i++) begin
         a = beat_addr(a0, b, i);
         e = err_exp(cur, a);
         check("burst_ack", 32'(ack[cur]), 32'(!e));
         check("burst_err", 32'(err[cur]), 32'(e));
         if (e) begin
            check("burst_err_dat", dat_r[cur], 32'h0);
            ended = 1'b1;
            break;
         end
         if (!w) check("burst_rdata", dat_r[cur], mem_m[cur][idx_of(a)]);
         adr[cur] = a;
         cti[cur] = (cti_end && i == nb - 1) ? CTI_EOB : CTI_INCR;
         if (w) begin
            dat_w[cur] = $urandom;
            sel[cur]   = 4'($urandom);
            model_write(cur, a, dat_w[cur], sel[cur]);
         end
         @(negedge clk);
      end
      if (!ended && !cti_end) begin
         a = beat_addr(a0, b, nb);
         e = err_exp(cur, a);
         check("burst_offered_ack", 32'(ack[cur]), 32'(!e));
         check("burst_offered_err", 32'(err[cur]), 32'(e));
         cyc[cur] = 1'b0;
         stb[cur] = 1'b0;
         @(negedge clk);
      end else if (ended) begin
         cyc[cur] = 1'b0;
         stb[cur] = 1'b0;
         @(negedge clk);
      end
      check("burst_end", {30'b0, ack[cur], err[cur]}, 32'h0);
      bus_idle(cur);
   endtask

   //---------------------------------------------------------------------------
   // Main sequence
   //---------------------------------------------------------------------------
   initial begin
      logic [31:0] rd;
      logic [31:0] keep0, keep1;
      bus_idle(0);
      bus_idle(1);

      // Reset values
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         cur = d;
         check("rst_ack", 32'(ack[d]), 32'h0);
         check("rst_err", 32'(err[d]), 32'h0);
         check("rst_rty", 32'(rty[d]), 32'h0);
         check("rst_dat", dat_r[d], 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Give every word a known value
      for (int d = 0; d < 2; d++) begin
         cur = d;
         for (int i = 0; i < DEPTH; i++)
            classic(1'b1, base_of(d) + 32'(i * 4), $urandom, 4'hF, rd);
      end

      // Full-word write then read back
      cur = 0;
      classic(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd);
      classic(1'b0, 32'h10, 32'h0, 4'hF, rd);
      check("t1_rdata", rd, 32'hDEAD_BEEF);

      // Partial write with wait states
      cur = 1;
      classic(1'b1, 32'h1010, 32'hDEAD_BEEF, 4'hF, rd);
      classic(1'b1, 32'h1010, 32'h1234_5678, 4'b0011, rd);
      classic(1'b0, 32'h1010, 32'h0, 4'hF, rd);
      check("t2_rdata", rd, 32'hDEAD_5678);
      classic(1'b1, 32'h1014, 32'hFFFF_FFFF, 4'b0000, rd);
      classic(1'b0, 32'h1014, 32'h0, 4'hF, rd);

      // Wrap4 read burst from 0x0C, linear burst abandoned after 2 beats
      for (int d = 0; d < 2; d++) begin
         cur = d;
         burst(1'b0, base_of(d) + 32'h0C, 2'b01, 4, 1'b1);
         burst(1'b0, base_of(d) + 32'h20, 2'b00, 2, 1'b0);
         classic(1'b0, base_of(d) + 32'h40, 32'h0, 4'hF, rd);
      end

      // Window edge: access just past the window, linear burst across the top
      for (int d = 0; d < 2; d++) begin
         cur = d;
         classic(1'b0, base_of(d) + CAP, 32'h0, 4'hF, rd);
         classic(1'b1, base_of(d) + CAP, 32'hA5A5_5A5A, 4'hF, rd);
         classic(1'b0, base_of(d), 32'h0, 4'hF, rd);
         burst(1'b0, base_of(d) + CAP - 32'd4, 2'b00, 3, 1'b1);
      end

      // Randomized traffic
      for (int d = 0; d < 2; d++) begin
         cur = d;
         for (int k = 0; k < 150; k++) begin
            case ($urandom_range(3))
               0: classic(1'b1, rand_addr(d), $urandom, 4'($urandom), rd);
               1: classic(1'b0, rand_addr(d), 32'h0, 4'hF, rd);
               2: burst(1'b0, rand_addr(d), 2'($urandom), int'($urandom_range(6, 1)),
                        1'($urandom_range(1)));
               default: burst(1'b1, rand_addr(d), 2'($urandom),
                              int'($urandom_range(6, 1)), 1'($urandom_range(1)));
            endcase
         end
      end

      // Reset in the middle of a write burst: beat 1 completes, beat 2 is lost
      cur   = 0;
      keep1 = mem_m[0][idx_of(32'h84)];
      keep0 = 32'h0BAD_F00D;
      @(negedge clk);
      adr[0]   = 32'h80;
      dat_w[0] = keep0;
      sel[0]   = 4'hF;
      we[0]    = 1'b1;
      cti[0]   = CTI_INCR;
      bte[0]   = 2'b00;
      cyc[0]   = 1'b1;
      stb[0]   = 1'b1;
      @(negedge clk);
      check("rst_burst_beat1_ack", 32'(ack[0]), 32'h1);
      model_write(0, 32'h80, keep0, 4'hF);
      @(negedge clk);
      check("rst_burst_beat2_ack", 32'(ack[0]), 32'h1);
      adr[0]   = 32'h84;
      dat_w[0] = ~keep1;
      rst      = 1'b1;
      #1;
      check("rst_async_ack", 32'(ack[0]), 32'h0);
      check("rst_async_err", 32'(err[0]), 32'h0);
      check("rst_async_dat", dat_r[0], 32'h0);
      bus_idle(0);
      @(negedge clk);
      rst = 1'b0;
      classic(1'b0, 32'h80, 32'h0, 4'hF, rd);
      check("rst_kept_beat1", rd, keep0);
      classic(1'b0, 32'h84, 32'h0, 4'hF, rd);
      check("rst_dropped_beat2", rd, keep1);

      // Sweep both memories against the model
      for (int d = 0; d < 2; d++) begin
         cur = d;
         for (int i = 0; i < DEPTH; i++)
            classic(1'b0, base_of(d) + 32'(i * 4), 32'h0, 4'hF, rd);
         check("rty_low", 32'(rty[d]), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got=running expected=done");
      $fatal(1);
   end

endmodule
